// File: rtl/clock_mon_pkg.sv
// Shared state encoding, default timing constants and the period tolerance check
// for the clock edge monitor.
package clock_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_LOST    = 2'd3
   } state_t;

   localparam int DEF_EXP_PERIOD = 4;
   localparam int DEF_TIMEOUT    = 16;

   // True when |p - exp| <= tol, evaluated without signed wrap-around.
   function automatic logic within_tol(input int p, input int exp, input int tol);
      if (p >= exp) return ((p - exp) <= tol);
      else          return ((exp - p) <= tol);
   endfunction

endpackage

// File: rtl/clock_edge_monitor_sync.sv
// Synchronizes the divided clock into clk_i and turns its edges into registered
// single-cycle rise/fall strobes.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst,
   input  logic clk_div_i,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   sync_lvl;

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         rise_o <= 1'b0;
         fall_o <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], clk_div_i};
         hist_q <= sync_lvl;
         rise_o <= sync_lvl & ~hist_q;
         fall_o <= ~sync_lvl & hist_q;
      end
   end

endmodule

// File: rtl/clock_edge_monitor.sv
// Watches a divided clock from the clk_i domain: edge strobes, rise-to-rise
// period measurement and an IDLE/ACQUIRE/LOCKED/LOST lock tracker.
module clock_edge_monitor
   import clock_mon_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int EXP_PERIOD  = DEF_EXP_PERIOD,
   parameter int TOL         = 0,
   parameter int LOCK_COUNT  = 4,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  logic             clk_i,
   input  logic             rst,
   input  logic             clk_div_i,
   output logic             rise_o,
   output logic             fall_o,
   output logic [CNT_W-1:0] period_o,
   output logic             locked_o,
   output logic             lost_o,
   output logic             err_o,
   output state_t           state_o
);

   localparam int               GW        = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] PCNT_MAX  = '1;
   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
   localparam logic [GW-1:0]    LAST_GOOD = GW'(LOCK_COUNT - 1);

   logic [CNT_W-1:0] pcnt;
   logic [GW-1:0]    good_cnt;
   logic             match;
   logic             timeout;
   state_t           state;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge (
      .clk_i     (clk_i),
      .rst       (rst),
      .clk_div_i (clk_div_i),
      .rise_o    (rise_o),
      .fall_o    (fall_o)
   );

   assign match   = within_tol(int'(pcnt), EXP_PERIOD, TOL);
   assign timeout = (pcnt >= TIMEOUT_V);
   assign state_o = state;

   // The first rise after IDLE/LOST ends a gap, not a period, so it is not recorded.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         pcnt     <= '0;
         period_o <= '0;
      end else if (rise_o) begin
         pcnt <= CNT_W'(1);
         if (state == ST_ACQUIRE || state == ST_LOCKED) period_o <= pcnt;
      end else if (pcnt != PCNT_MAX) begin
         pcnt <= pcnt + CNT_W'(1);
      end
   end

   // A rise always takes priority over the timeout in the same cycle.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         good_cnt <= '0;
         locked_o <= 1'b0;
         lost_o   <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         err_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rise_o) begin
                  state    <= ST_ACQUIRE;
                  good_cnt <= '0;
               end else if (timeout) begin
                  state  <= ST_LOST;
                  lost_o <= 1'b1;
               end
            end
            ST_ACQUIRE: begin
               if (rise_o) begin
                  if (!match) begin
                     good_cnt <= '0;
                  end else if (good_cnt == LAST_GOOD) begin
                     state    <= ST_LOCKED;
                     locked_o <= 1'b1;
                     good_cnt <= '0;
                  end else begin
                     good_cnt <= good_cnt + GW'(1);
                  end
               end else if (timeout) begin
                  state    <= ST_LOST;
                  lost_o   <= 1'b1;
                  good_cnt <= '0;
               end
            end
            ST_LOCKED: begin
               if (rise_o) begin
                  if (!match) begin
                     state    <= ST_ACQUIRE;
                     locked_o <= 1'b0;
                     err_o    <= 1'b1;
                     good_cnt <= '0;
                  end
               end else if (timeout) begin
                  state    <= ST_LOST;
                  locked_o <= 1'b0;
                  lost_o   <= 1'b1;
               end
            end
            ST_LOST: begin
               if (rise_o) begin
                  state    <= ST_ACQUIRE;
                  lost_o   <= 1'b0;
                  good_cnt <= '0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               locked_o <= 1'b0;
               lost_o   <= 1'b0;
               good_cnt <= '0;
            end
         endcase
      end
   end

endmodule
